sequence_player: RTL and testbench
==================================

SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the color code driven to the LED driver stage.
REQ-002 Parameter MAX_LEN, default 32, depth of the sequence memory (number of color steps).
REQ-003 Parameter ON_CYCLES, default 50_000_000, clock cycles each color is shown.
REQ-004 Parameter OFF_CYCLES, default 25_000_000, clock cycles of dark gap after each color.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 wr_en  input  1  sequence memory write strobe.
REQ-008 wr_addr  input  $clog2(MAX_LEN)  write address.
REQ-009 wr_color  input  2  color to store: 0 green, 1 blue, 2 red, 3 yellow.
REQ-010 seq_len  input  $clog2(MAX_LEN)+1  number of steps to play; sampled on accepted start.
REQ-011 start  input  1  single-cycle request to begin playback.
REQ-012 abort  input  1  stop playback immediately.
REQ-013 color_out  output  DATA_WIDTH  color code to the LED driver stage.
REQ-014 busy  output  1  high while playback in progress.
REQ-015 done  output  1  one-cycle pulse at playback end (normal, empty or aborted).

Function
REQ-016 FSM states SHALL be IDLE, SHOW, GAP.
REQ-017 IDLE: start with sampled seq_len in 1..MAX_LEN SHALL latch length, clear step index, load timer with ON_CYCLES, enter SHOW next cycle.
REQ-018 start with seq_len = 0 or seq_len > MAX_LEN SHALL stay IDLE and assert done the following cycle.
REQ-019 SHOW: color_out SHALL equal zero-extended mem[index]; after exactly ON_CYCLES cycles in SHOW, enter GAP loaded with OFF_CYCLES.
REQ-020 GAP: color_out SHALL equal IDLE_CODE (all ones); after exactly OFF_CYCLES cycles, if index = length-1 go IDLE with done pulse, else index+1 and re-enter SHOW.
REQ-021 color_out SHALL be registered; first SHOW color visible the cycle after start is accepted.
REQ-022 busy SHALL be high in SHOW and GAP, low in IDLE.
REQ-023 start while busy SHALL be ignored; seq_len changes during playback SHALL have no effect.
REQ-024 wr_en while busy SHALL be ignored (memory contents frozen during playback); wr_en in IDLE writes on that edge; wr_addr >= MAX_LEN ignored.
REQ-025 wr_en and start in the same IDLE cycle: write SHALL take effect and playback SHALL see the new value.
REQ-026 abort in SHOW or GAP SHALL go IDLE next cycle, color_out IDLE_CODE, done pulsed once; abort in IDLE ignored; abort has priority over timer expiry.
REQ-027 Index SHALL never wrap; full-length playback (seq_len = MAX_LEN) SHALL end after last step.

Reset
REQ-028 On rst: state IDLE, color_out IDLE_CODE, busy 0, done 0, index 0, timer 0; memory contents unspecified.
REQ-029 rst mid-playback SHALL end playback without a done pulse.

Structure
REQ-030 Shared package genius_pkg SHALL hold color enum (GREEN, BLUE, RED, YELLOW), IDLE_CODE, and FSM state typedef.
REQ-031 One sub-module cycle_timer (load value, decrement, expire flag) SHALL implement SHOW/GAP timing.

Verification (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=8)
REQ-032 Write {2,0,3}, start with seq_len=3 -> color_out 2 for 4 cycles, FF 2, 0 4, FF 2, 3 4, FF 2; done one cycle; busy 18 cycles.
REQ-033 start with seq_len=0 -> busy stays 0, done pulses next cycle, color_out FF.
REQ-034 Abort in second SHOW cycle of step 1 -> next cycle IDLE, color_out FF, single done pulse.
REQ-035 wr_en to addr 0 with color 1 during playback -> ignored; replay shows original color.
REQ-036 rst asserted during GAP -> immediate IDLE, color_out FF, busy 0, no done pulse.
REQ-037 seq_len=8 all entries 3 -> eight SHOW/GAP pairs, index ends without wrap, one done.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the sequence player: color codes, FSM states
// and the "dark" code driven to the LED stage when no color is being shown.
package genius_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      BLUE   = 2'd1,
      RED    = 2'd2,
      YELLOW = 2'd3
   } color_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_e;

   // Wide enough for any practical DATA_WIDTH; users take the low bits.
   localparam logic [63:0] IDLE_CODE = '1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Host-side bus of the sequence player: memory writes, playback control and
// the registered color/status outputs toward the LED driver stage.
interface sequence_player_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 32
);
   logic                         wr_en;
   logic [$clog2(MAX_LEN)-1:0]   wr_addr;
   logic [1:0]                   wr_color;
   logic [$clog2(MAX_LEN):0]     seq_len;
   logic                         start;
   logic                         abort;
   logic [DATA_WIDTH-1:0]        color_out;
   logic                         busy;
   logic                         done;

   modport master (
      output wr_en, wr_addr, wr_color, seq_len, start, abort,
      input  color_out, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_color, seq_len, start, abort,
      output color_out, busy, done
   );
endinterface

// File: rtl/sequence_player_cycle_timer.sv
// Down-counter that times each SHOW and GAP phase; expired is high during the
// last cycle of a loaded interval so the phase lasts exactly load_val cycles.
module cycle_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);
   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == WIDTH'(1));
endmodule

// File: rtl/sequence_player.sv
// Plays back a stored list of colors: each color for ON_CYCLES, then a dark gap
// of OFF_CYCLES, until the requested length is exhausted or playback is aborted.
module sequence_player
   import genius_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 32,
   parameter int ON_CYCLES  = 50_000_000,
   parameter int OFF_CYCLES = 25_000_000
) (
   input  logic               clk,
   input  logic               rst,
   sequence_player_if.slave   bus
);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = IDX_W + 1;
   localparam int TMR_W = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
   localparam logic [DATA_WIDTH-1:0] IDLE_COLOR = IDLE_CODE[DATA_WIDTH-1:0];

   function automatic logic [DATA_WIDTH-1:0] color_code(input color_e c);
      logic [DATA_WIDTH-1:0] r;
      r      = '0;
      r[1:0] = c;
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [DATA_WIDTH-1:0] color_q, color_d;
   logic                  done_q, done_d;
   logic                  tmr_load, tmr_dec, tmr_exp;
   logic [TMR_W-1:0]      tmr_val;
   logic                  mem_wr, len_ok, last_step;
   color_e                first_color;
   color_e                mem [MAX_LEN];

   // Writes are only accepted while idle, so the list is frozen during playback.
   assign mem_wr = (state_q == IDLE) && bus.wr_en && (int'(bus.wr_addr) < MAX_LEN);

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[bus.wr_addr] <= color_e'(bus.wr_color);
      end
   end

   // A write to entry 0 in the start cycle must be what the first step shows.
   assign first_color = (mem_wr && (bus.wr_addr == '0)) ? color_e'(bus.wr_color) : mem[0];
   assign len_ok      = (bus.seq_len != '0) && (int'(bus.seq_len) <= MAX_LEN);
   assign last_step   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
   assign idx_inc     = idx_q + 1'b1;

   cycle_timer #(.WIDTH(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         color_q <= IDLE_COLOR;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         color_q <= color_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      color_d  = color_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(ON_CYCLES);
      tmr_dec  = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  state_d  = SHOW;
                  len_d    = bus.seq_len;
                  idx_d    = '0;
                  color_d  = color_code(first_color);
                  tmr_load = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SHOW: begin
            // Abort wins over a timer expiring in the same cycle.
            if (bus.abort) begin
               state_d = IDLE;
               color_d = IDLE_COLOR;
               done_d  = 1'b1;
            end else if (tmr_exp) begin
               state_d  = GAP;
               color_d  = IDLE_COLOR;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(OFF_CYCLES);
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_d = IDLE;
               color_d = IDLE_COLOR;
               done_d  = 1'b1;
            end else if (tmr_exp) begin
               if (last_step) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = SHOW;
                  idx_d    = idx_inc;
                  color_d  = color_code(mem[idx_inc]);
                  tmr_load = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            color_d = IDLE_COLOR;
         end
      endcase
   end

   assign bus.color_out = color_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON=4, OFF=2, MAX_LEN=8: a vector
// table for idle-side behavior plus hand sequences for playback corner cases.
module tb_sequence_player;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sequence_player_if #(.DATA_WIDTH(8), .MAX_LEN(8)) sif ();

   sequence_player #(
      .DATA_WIDTH (8),
      .MAX_LEN    (8),
      .ON_CYCLES  (4),
      .OFF_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wen;
      logic [2:0] waddr;
      logic [1:0] wcol;
      logic [3:0] len;
      logic       st;
      logic       ab;
      logic [7:0] ecol;
      logic       ebusy;
      logic       edone;
   } vec_t;

   vec_t       vt [10];
   logic [1:0] ecols [8];

   task automatic chk(input string name, input logic [7:0] ecol, input logic ebusy, input logic edone);
      checks++;
      if (sif.color_out !== ecol || sif.busy !== ebusy || sif.done !== edone) begin
         errors++;
         $display("FAIL %s: got color=%h busy=%b done=%b, want color=%h busy=%b done=%b",
                  name, sif.color_out, sif.busy, sif.done, ecol, ebusy, edone);
      end
   endtask

   // Checks n cycles of playback starting the cycle after start was driven.
   task automatic watch(input int n, input bit disturb);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = ((i % 6) < 4) ? {6'b0, ecols[i / 6]} : 8'hFF;
         chk($sformatf("play_cyc%0d", i), e, 1'b1, 1'b0);
         sif.start = 1'b0;
         sif.wr_en = 1'b0;
         if (disturb && i == 3) begin
            sif.start    = 1'b1;
            sif.seq_len  = 4'd1;
            sif.wr_en    = 1'b1;
            sif.wr_addr  = 3'd0;
            sif.wr_color = 2'd1;
         end
      end
      sif.start = 1'b0;
      sif.wr_en = 1'b0;
   endtask

   task automatic play(input int len, input bit disturb, input logic wen, input logic [2:0] waddr,
                       input logic [1:0] wcol);
      sif.wr_en    = wen;
      sif.wr_addr  = waddr;
      sif.wr_color = wcol;
      sif.seq_len  = 4'(len);
      sif.start    = 1'b1;
      watch(6 * len, disturb);
      @(negedge clk);
      chk("play_done", 8'hFF, 1'b0, 1'b1);
      @(negedge clk);
      chk("play_after", 8'hFF, 1'b0, 1'b0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      sif.wr_en    = 1'b0;
      sif.wr_addr  = '0;
      sif.wr_color = '0;
      sif.seq_len  = '0;
      sif.start    = 1'b0;
      sif.abort    = 1'b0;

      //            wen waddr wcol len st ab  ecol  busy done
      vt[0] = '{1'b1, 3'd0, 2'd2, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[1] = '{1'b1, 3'd1, 2'd0, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[2] = '{1'b1, 3'd2, 2'd3, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[3] = '{1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
      vt[4] = '{1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[5] = '{1'b0, 3'd0, 2'd0, 4'd9, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
      vt[6] = '{1'b0, 3'd0, 2'd0, 4'd9, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[8] = '{1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[9] = '{1'b0, 3'd0, 2'd0, 4'd15, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};

      repeat (2) @(negedge clk);
      chk("reset_state", 8'hFF, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset", 8'hFF, 1'b0, 1'b0);

      for (int v = 0; v < 10; v++) begin
         sif.wr_en    = vt[v].wen;
         sif.wr_addr  = vt[v].waddr;
         sif.wr_color = vt[v].wcol;
         sif.seq_len  = vt[v].len;
         sif.start    = vt[v].st;
         sif.abort    = vt[v].ab;
         @(negedge clk);
         chk($sformatf("vec%0d", v), vt[v].ecol, vt[v].ebusy, vt[v].edone);
      end
      sif.wr_en = 1'b0;
      sif.start = 1'b0;
      sif.abort = 1'b0;

      // Full 3-step playback, with start/seq_len/write attempts mid-play.
      ecols = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      play(3, 1'b1, 1'b0, 3'd0, 2'd0);
      // Replay: entry 0 must still hold the original color.
      play(3, 1'b0, 1'b0, 3'd0, 2'd0);

      // Write and start in the same cycle: first step shows the new value.
      ecols[0] = 2'd3;
      play(1, 1'b0, 1'b1, 3'd0, 2'd3);

      // Abort in the second SHOW cycle of step index 1.
      sif.seq_len = 4'd3;
      sif.start   = 1'b1;
      watch(8, 1'b0);
      sif.abort = 1'b1;
      @(negedge clk);
      chk("abort_done", 8'hFF, 1'b0, 1'b1);
      sif.abort = 1'b0;
      @(negedge clk);
      chk("abort_after", 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      chk("abort_after2", 8'hFF, 1'b0, 1'b0);

      // Abort in the cycle the SHOW timer expires.
      sif.seq_len = 4'd1;
      sif.start   = 1'b1;
      watch(4, 1'b0);
      sif.abort = 1'b1;
      @(negedge clk);
      chk("abort_prio_done", 8'hFF, 1'b0, 1'b1);
      sif.abort = 1'b0;
      @(negedge clk);
      chk("abort_prio_after", 8'hFF, 1'b0, 1'b0);

      // Reset during the first GAP cycle.
      sif.seq_len = 4'd3;
      sif.start   = 1'b1;
      watch(5, 1'b0);
      #2 rst = 1'b1;
      #1 chk("rst_async", 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_no_done", 8'hFF, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release", 8'hFF, 1'b0, 1'b0);

      // Full-length playback of eight yellow steps.
      for (int a = 0; a < 8; a++) begin
         sif.wr_en    = 1'b1;
         sif.wr_addr  = 3'(a);
         sif.wr_color = 2'd3;
         @(negedge clk);
         chk($sformatf("fill%0d", a), 8'hFF, 1'b0, 1'b0);
      end
      sif.wr_en = 1'b0;
      for (int a = 0; a < 8; a++) ecols[a] = 2'd3;
      play(8, 1'b0, 1'b0, 3'd0, 2'd0);

      // Index restarts from zero after a full run.
      play(1, 1'b0, 1'b0, 3'd0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
